// File: rtl/objects_mux_gameover.sv
// Pixel compositor: picks one pixel per clock by fixed layer priority and registers it for VGA.
// A frame-counted FSM makes the game-over layer blink, then hold (optionally dimming the scene).
module objects_mux_gameover #(
  parameter int unsigned BLINK_FRAMES = 30,
  parameter int unsigned BLINK_COUNT  = 3,
  parameter int unsigned DIM_ENABLE   = 1
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       GAMEOVER,
  input  logic       gameOverDrawingRequest,
  input  logic [7:0] gameOverRGB,
  input  logic       birdDrawingRequest,
  input  logic [7:0] birdRGB,
  input  logic       pigDrawingRequest,
  input  logic [7:0] pigRGB,
  input  logic       blockDrawingRequest,
  input  logic [7:0] blockRGB,
  input  logic [7:0] backGroundRGB,
  output logic [7:0] RGBOut,
  output logic       gameOverVisible,
  output logic       holdReached
);

  typedef enum logic [1:0] {IDLE, BLINK_ON, BLINK_OFF, HOLD} state_e;

  localparam logic [7:0] FRAME_LAST = 8'(BLINK_FRAMES - 1);
  localparam logic [3:0] BLINK_LAST = 4'(BLINK_COUNT);

  state_e     state_q, state_d;
  logic [7:0] frame_q, frame_d;
  logic [3:0] blink_q, blink_d;
  logic [7:0] rgb_q, rgb_d;
  logic       vis_q, hold_q;

  logic       visible;
  logic       in_hold;
  logic       from_go;
  logic [7:0] pix;

  assign visible = (state_q == BLINK_ON) || (state_q == HOLD);
  assign in_hold = (state_q == HOLD);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    frame_d = frame_q;
    blink_d = blink_q;
    if (!GAMEOVER) begin
      state_d = IDLE;
      frame_d = '0;
      blink_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = BLINK_ON;
          frame_d = '0;
          blink_d = '0;
        end
        BLINK_ON, BLINK_OFF: begin
          if (startOfFrame) begin
            if (frame_q == FRAME_LAST) begin
              frame_d = '0;
              if (state_q == BLINK_ON) begin
                blink_d = blink_q + 4'd1;
                state_d = (blink_q + 4'd1 == BLINK_LAST) ? HOLD : BLINK_OFF;
              end else begin
                state_d = BLINK_ON;
              end
            end else begin
              frame_d = frame_q + 8'd1;
            end
          end
        end
        HOLD: state_d = HOLD;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    from_go = 1'b0;
    pix     = backGroundRGB;
    if (gameOverDrawingRequest && visible) begin
      pix     = gameOverRGB;
      from_go = 1'b1;
    end else if (birdDrawingRequest) begin
      pix = birdRGB;
    end else if (pigDrawingRequest) begin
      pix = pigRGB;
    end else if (blockDrawingRequest) begin
      pix = blockRGB;
    end
    rgb_d = pix;
    // Each RGB332 field shifts right on its own, zero-filled from the top.
    if ((DIM_ENABLE != 0) && in_hold && !from_go) begin
      rgb_d = {1'b0, pix[7:6], 1'b0, pix[4:3], 1'b0, pix[1]};
    end
  end

  // NOTE: all state, including the output pixel, clears on the async reset so the VGA sees black at once.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      frame_q <= '0;
      blink_q <= '0;
      rgb_q   <= '0;
      vis_q   <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      frame_q <= frame_d;
      blink_q <= blink_d;
      rgb_q   <= rgb_d;
      vis_q   <= visible;
      hold_q  <= in_hold;
    end
  end

  assign RGBOut          = rgb_q;
  assign gameOverVisible = vis_q;
  assign holdReached     = hold_q;

endmodule

// File: tb/tb_objects_mux_gameover.sv
// Self-checking bench: a phase model counts frames since game over and derives the expected
// pixel, visibility and hold flags; scenario tasks compare the DUT against it.
module tb_objects_mux_gameover;

  localparam int BF        = 2;
  localparam int BC        = 3;
  localparam int HOLD_SOFS = BF * (2 * BC - 1);

  logic       clk = 1'b0;
  logic       resetN;
  logic       sof, game_over;
  logic       go_req, bird_req, pig_req, block_req;
  logic [7:0] go_rgb, bird_rgb, pig_rgb, block_rgb, bg_rgb;
  logic [7:0] rgb_out;
  logic       vis_out, hold_out;

  int checks   = 0;
  int failures = 0;

  // Model: whether the game-over sequence is running, and SOFs counted since it started.
  bit m_active = 1'b0;
  int m_sofs   = 0;

  logic [7:0] e_rgb;
  logic       e_vis, e_hold;

  objects_mux_gameover #(.BLINK_FRAMES(BF), .BLINK_COUNT(BC), .DIM_ENABLE(1)) dut (
    .clk                    (clk),
    .resetN                 (resetN),
    .startOfFrame           (sof),
    .GAMEOVER               (game_over),
    .gameOverDrawingRequest (go_req),
    .gameOverRGB            (go_rgb),
    .birdDrawingRequest     (bird_req),
    .birdRGB                (bird_rgb),
    .pigDrawingRequest      (pig_req),
    .pigRGB                 (pig_rgb),
    .blockDrawingRequest    (block_req),
    .blockRGB               (block_rgb),
    .backGroundRGB          (bg_rgb),
    .RGBOut                 (rgb_out),
    .gameOverVisible        (vis_out),
    .holdReached            (hold_out)
  );

  always #5 clk = ~clk;

  // Predicts the registered outputs from current inputs and model, then advances one clock.
  task automatic cycle(output logic [7:0] x_rgb, output logic x_vis, output logic x_hold);
    bit         hold, vis, from_go;
    logic [7:0] p;
    hold    = m_active && (m_sofs >= HOLD_SOFS);
    vis     = m_active && (hold || ((m_sofs / BF) % 2 == 0));
    from_go = 1'b0;
    if (go_req && vis) begin p = go_rgb; from_go = 1'b1; end
    else if (bird_req)  p = bird_rgb;
    else if (pig_req)   p = pig_rgb;
    else if (block_req) p = block_rgb;
    else                p = bg_rgb;
    if (hold && !from_go)
      p = {3'(p[7:5] / 2), 3'(p[4:2] / 2), 2'(p[1:0] / 2)};
    x_rgb  = p;
    x_vis  = vis;
    x_hold = hold;
    @(posedge clk);
    if (!game_over) begin
      m_active = 1'b0;
      m_sofs   = 0;
    end else if (!m_active) begin
      m_active = 1'b1;
      m_sofs   = 0;
    end else if (sof) begin
      m_sofs++;
    end
    #1;
  endtask

  task automatic clear_inputs();
    sof = 0; game_over = 0; go_req = 0; bird_req = 0; pig_req = 0; block_req = 0;
    go_rgb = 8'h00; bird_rgb = 8'h00; pig_rgb = 8'h00; block_rgb = 8'h00; bg_rgb = 8'h00;
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    clear_inputs();
    #3;
    checks++; if (rgb_out !== 8'h00) begin failures++; $display("FAIL reset_rgb got=%h exp=00", rgb_out); end
    checks++; if (vis_out !== 1'b0) begin failures++; $display("FAIL reset_vis got=%b exp=0", vis_out); end
    checks++; if (hold_out !== 1'b0) begin failures++; $display("FAIL reset_hold got=%b exp=0", hold_out); end
    @(posedge clk); #2;
    resetN = 1'b1;
  endtask

  task automatic test_background();
    bg_rgb = 8'h2A;
    cycle(e_rgb, e_vis, e_hold);
    checks++; if (rgb_out !== 8'h2A) begin failures++; $display("FAIL bg_rgb got=%h exp=2a", rgb_out); end
    checks++; if (vis_out !== 1'b0) begin failures++; $display("FAIL bg_vis got=%b exp=0", vis_out); end
  endtask

  task automatic test_priority();
    bird_req = 1; pig_req = 1; block_req = 1;
    bird_rgb = 8'hE0; pig_rgb = 8'h1C; block_rgb = 8'h03;
    cycle(e_rgb, e_vis, e_hold);
    checks++; if (rgb_out !== 8'hE0) begin failures++; $display("FAIL prio_bird got=%h exp=e0", rgb_out); end
    bird_req = 0;
    cycle(e_rgb, e_vis, e_hold);
    checks++; if (rgb_out !== 8'h1C) begin failures++; $display("FAIL prio_pig got=%h exp=1c", rgb_out); end
    pig_req = 0;
    cycle(e_rgb, e_vis, e_hold);
    checks++; if (rgb_out !== 8'h03) begin failures++; $display("FAIL prio_block got=%h exp=03", rgb_out); end
  endtask

  task automatic test_random_priority();
    for (int i = 0; i < 40; i++) begin
      {go_req, bird_req, pig_req, block_req} = 4'($urandom);
      go_rgb = 8'($urandom); bird_rgb = 8'($urandom); pig_rgb = 8'($urandom);
      block_rgb = 8'($urandom); bg_rgb = 8'($urandom);
      sof = 1'($urandom);
      cycle(e_rgb, e_vis, e_hold);
      checks++; if (rgb_out !== e_rgb) begin failures++; $display("FAIL rand_prio_rgb i=%0d got=%h exp=%h", i, rgb_out, e_rgb); end
    end
    clear_inputs();
  endtask

  task automatic test_blink();
    game_over = 1; go_req = 1; go_rgb = 8'h1C; bird_req = 1; bird_rgb = 8'hE0;
    cycle(e_rgb, e_vis, e_hold);
    checks++; if (rgb_out !== 8'hE0) begin failures++; $display("FAIL blink_idle got=%h exp=e0", rgb_out); end
    for (int s = 0; s < HOLD_SOFS; s++) begin
      for (int k = 0; k < 3; k++) begin
        sof = (k == 2);
        cycle(e_rgb, e_vis, e_hold);
        sof = 0;
        checks++;
        if (rgb_out !== e_rgb || vis_out !== e_vis || hold_out !== e_hold) begin
          failures++;
          $display("FAIL blink sof=%0d k=%0d got=%h/%b/%b exp=%h/%b/%b",
                   s, k, rgb_out, vis_out, hold_out, e_rgb, e_vis, e_hold);
        end
      end
    end
    cycle(e_rgb, e_vis, e_hold);
    checks++; if (hold_out !== 1'b1) begin failures++; $display("FAIL blink_hold got=%b exp=1", hold_out); end
    checks++; if (rgb_out !== 8'h1C) begin failures++; $display("FAIL blink_hold_rgb got=%h exp=1c", rgb_out); end
  endtask

  task automatic test_hold_dim();
    go_req = 0; bird_req = 0; bg_rgb = 8'hFF;
    cycle(e_rgb, e_vis, e_hold);
    checks++; if (rgb_out !== 8'h6D) begin failures++; $display("FAIL dim_bg got=%h exp=6d", rgb_out); end
    go_req = 1; go_rgb = 8'hFF;
    cycle(e_rgb, e_vis, e_hold);
    checks++; if (rgb_out !== 8'hFF) begin failures++; $display("FAIL dim_go got=%h exp=ff", rgb_out); end
    for (int i = 0; i < 30; i++) begin
      {go_req, bird_req, pig_req, block_req} = 4'($urandom);
      go_rgb = 8'($urandom); bird_rgb = 8'($urandom); pig_rgb = 8'($urandom);
      block_rgb = 8'($urandom); bg_rgb = 8'($urandom);
      sof = 1'($urandom);
      cycle(e_rgb, e_vis, e_hold);
      checks++;
      if (rgb_out !== e_rgb || hold_out !== 1'b1) begin
        failures++;
        $display("FAIL dim_rand i=%0d got=%h/%b exp=%h/1", i, rgb_out, hold_out, e_rgb);
      end
    end
  endtask

  task automatic test_drop_in_off();
    clear_inputs();
    go_rgb = 8'h1C; bg_rgb = 8'h55; go_req = 1;
    cycle(e_rgb, e_vis, e_hold);
    game_over = 1;
    cycle(e_rgb, e_vis, e_hold);
    for (int s = 0; s < BF; s++) begin
      cycle(e_rgb, e_vis, e_hold);
      sof = 1; cycle(e_rgb, e_vis, e_hold); sof = 0;
    end
    cycle(e_rgb, e_vis, e_hold);
    checks++; if (vis_out !== 1'b0) begin failures++; $display("FAIL off_vis got=%b exp=0", vis_out); end
    game_over = 0; sof = 1;
    cycle(e_rgb, e_vis, e_hold);
    sof = 0;
    cycle(e_rgb, e_vis, e_hold);
    checks++; if (vis_out !== 1'b0 || rgb_out !== 8'h55) begin failures++; $display("FAIL drop_idle got=%b/%h exp=0/55", vis_out, rgb_out); end
    game_over = 1;
    for (int i = 0; i < 8; i++) begin
      sof = (i % 2 == 1);
      cycle(e_rgb, e_vis, e_hold);
      sof = 0;
      checks++;
      if (rgb_out !== e_rgb || vis_out !== e_vis) begin
        failures++;
        $display("FAIL restart i=%0d got=%h/%b exp=%h/%b", i, rgb_out, vis_out, e_rgb, e_vis);
      end
    end
  endtask

  task automatic test_reset_mid_blink();
    clear_inputs();
    cycle(e_rgb, e_vis, e_hold);
    game_over = 1; go_req = 1; go_rgb = 8'h1C;
    cycle(e_rgb, e_vis, e_hold);
    cycle(e_rgb, e_vis, e_hold);
    checks++; if (vis_out !== 1'b1) begin failures++; $display("FAIL pre_reset_vis got=%b exp=1", vis_out); end
    resetN = 1'b0;
    #1;
    checks++; if (rgb_out !== 8'h00 || vis_out !== 1'b0) begin failures++; $display("FAIL async_reset got=%h/%b exp=00/0", rgb_out, vis_out); end
    m_active = 1'b0; m_sofs = 0;
    @(posedge clk); #2;
    resetN = 1'b1;
    cycle(e_rgb, e_vis, e_hold);
    checks++; if (vis_out !== 1'b0) begin failures++; $display("FAIL post_reset_first got=%b exp=0", vis_out); end
    cycle(e_rgb, e_vis, e_hold);
    checks++; if (vis_out !== 1'b1 || rgb_out !== 8'h1C) begin failures++; $display("FAIL post_reset_on got=%b/%h exp=1/1c", vis_out, rgb_out); end
  endtask

  task automatic test_random_gameover();
    for (int i = 0; i < 400; i++) begin
      game_over = ($urandom_range(0, 63) != 0);
      sof = ($urandom_range(0, 3) == 0);
      {go_req, bird_req, pig_req, block_req} = 4'($urandom);
      go_rgb = 8'($urandom); bird_rgb = 8'($urandom); pig_rgb = 8'($urandom);
      block_rgb = 8'($urandom); bg_rgb = 8'($urandom);
      cycle(e_rgb, e_vis, e_hold);
      checks++;
      if (rgb_out !== e_rgb || vis_out !== e_vis || hold_out !== e_hold) begin
        failures++;
        $display("FAIL rand_go i=%0d got=%h/%b/%b exp=%h/%b/%b",
                 i, rgb_out, vis_out, hold_out, e_rgb, e_vis, e_hold);
      end
    end
  endtask

  initial begin
    test_reset();
    test_background();
    test_priority();
    test_random_priority();
    test_blink();
    test_hold_dim();
    test_drop_in_off();
    test_reset_mid_blink();
    test_random_gameover();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
